// File: rtl/usb_hid_report_decoder.sv
// hid_evt_fifo: small generic FIFO used for the key make/break event queue.
// Latency: one cycle from push to visible at the head.
// Backpressure: a push when full is accepted only together with a pop; otherwise the caller sees full.
module hid_evt_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage write; contents need no reset since occupancy gates the head
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// usb_hid_report_decoder: captures low-speed HID frames, decodes keyboard/mouse state, emits key events.
// Latency: committed state and report pulse one cycle after the registered data_rdy fall; events follow over 2*NUM_KEYS cycles.
// Backpressure: none upstream; events queue in a FIFO, drops when full set sticky evt_ovf. Define USB_HID_WHEEL_EN for mouse_wheel.
module usb_hid_report_decoder #(
  parameter int MAX_REPORT_LEN = 8,
  parameter int NUM_KEYS       = 6,
  parameter int ACC_W          = 12,
  parameter int EVT_DEPTH      = 16
) (
  input  logic                  usbclk,
  input  logic                  usbrst_n,
  input  logic [1:0]            typ,
  input  logic                  data_rdy,
  input  logic                  data_strobe,
  input  logic [7:0]            data,
  output logic                  report,
  output logic [3:0]            report_len,
  output logic [7:0]            key_modifiers,
  output logic [8*NUM_KEYS-1:0] keys,
  output logic [7:0]            mouse_btn,
  output logic [ACC_W-1:0]      mouse_dx,
  output logic [ACC_W-1:0]      mouse_dy,
`ifdef USB_HID_WHEEL_EN
  output logic [ACC_W-1:0]      mouse_wheel,
`endif
  input  logic                  mouse_ack,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [7:0]            evt_code,
  output logic                  evt_make,
  output logic                  evt_ovf,
  input  logic                  evt_ovf_clr,
  output logic                  busy
);
  localparam int CNT_W  = $clog2(MAX_REPORT_LEN + 1);
  localparam int SLOT_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int KW     = 8 * NUM_KEYS;
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_REPORT_LEN);
  localparam logic [CNT_W-1:0]  KB_LEN    = CNT_W'(NUM_KEYS + 2);
  localparam logic [CNT_W-1:0]  MS_LEN    = CNT_W'(3);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_KEYS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_MAKE} state_t;

  logic                      rdy_q, strobe_q, strobe_rise, rdy_fall, byte_take;
  logic [CNT_W-1:0]          count;
  logic [8*MAX_REPORT_LEN-1:0] rx_flat;
  logic [1:0]                typ_q;
  logic                      disc, kb_err, kb_ok, ms_ok, commit_ok, kb_commit, ms_commit;
  state_t                    state, state_nx;
  logic [SLOT_W-1:0]         slot, slot_nx;
  logic                      disc_pass, disc_pass_nx;
  logic [KW-1:0]             held;
  logic [7:0]                old_code, new_code;
  logic                      evt_push, fifo_full, fifo_empty;
  logic [8:0]                evt_push_dat, fifo_dat;

  // True when code appears in any slot of arr
  function automatic logic in_arr(input logic [7:0] code, input logic [KW-1:0] arr);
    in_arr = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (arr[8*i +: 8] == code) in_arr = 1'b1;
  endfunction

  // Signed add of an 8-bit delta that clamps instead of wrapping
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc, input logic [7:0] d);
    logic [ACC_W:0] s;
    s = {acc[ACC_W-1], acc} + {{(ACC_W-7){d[7]}}, d};
    if (s[ACC_W] != s[ACC_W-1]) sat_add = {s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
    else                        sat_add = s[ACC_W-1:0];
  endfunction

  assign strobe_rise = data_strobe & ~strobe_q;
  assign rdy_fall    = rdy_q & ~data_rdy;
  assign byte_take   = rdy_q & strobe_rise & (count < MAX_CNT);
  assign disc        = (typ_q != 2'd0) && (typ == 2'd0);
  assign busy        = (state != S_IDLE);

  // Register frame controls, count bytes and store those that fit
  always_ff @(posedge usbclk or negedge usbrst_n) begin
    if (!usbrst_n) begin
      rdy_q    <= 1'b0;
      strobe_q <= 1'b0;
      count    <= '0;
      rx_flat  <= '0;
      typ_q    <= 2'd0;
    end else begin
      rdy_q    <= data_rdy;
      strobe_q <= data_strobe;
      typ_q    <= typ;
      if (!rdy_q) count <= '0;
      else if (byte_take) begin
        rx_flat[8*int'(count) +: 8] <= data;
        count <= count + 1'b1;
      end
    end
  end

  // Keyboard reports carrying the 0x01 rollover code in any slot are rejected
  always_comb begin
    kb_err = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (rx_flat[8*(i+2) +: 8] == 8'h01) kb_err = 1'b1;
  end

  assign kb_ok     = (typ == 2'd1) && (count >= KB_LEN) && !kb_err;
  assign ms_ok     = (typ == 2'd2) && (count >= MS_LEN);
  assign commit_ok = rdy_fall && (count != '0) && (state == S_IDLE) &&
                     (kb_ok || ms_ok || (typ == 2'd3));
  assign kb_commit = commit_ok && kb_ok;
  assign ms_commit = commit_ok && ms_ok;

  // Committed report state; a disconnect releases keys and buttons
  always_ff @(posedge usbclk or negedge usbrst_n) begin
    if (!usbrst_n) begin
      report        <= 1'b0;
      report_len    <= 4'd0;
      key_modifiers <= 8'h00;
      keys          <= '0;
      mouse_btn     <= 8'h00;
    end else begin
      report <= commit_ok;
      if (commit_ok) report_len <= 4'(count);
      if (disc) begin
        key_modifiers <= 8'h00;
        keys          <= '0;
        mouse_btn     <= 8'h00;
      end else if (kb_commit) begin
        key_modifiers <= rx_flat[7:0];
        keys          <= rx_flat[16 +: KW];
      end else if (ms_commit) begin
        mouse_btn <= rx_flat[7:0];
      end
    end
  end

  // Motion accumulators: an ack clears first, then a committed report adds its delta
  always_ff @(posedge usbclk or negedge usbrst_n) begin
    if (!usbrst_n) begin
      mouse_dx <= '0;
      mouse_dy <= '0;
`ifdef USB_HID_WHEEL_EN
      mouse_wheel <= '0;
`endif
    end else if (ms_commit) begin
      mouse_dx <= sat_add(mouse_ack ? {ACC_W{1'b0}} : mouse_dx, rx_flat[15:8]);
      mouse_dy <= sat_add(mouse_ack ? {ACC_W{1'b0}} : mouse_dy, rx_flat[23:16]);
`ifdef USB_HID_WHEEL_EN
      mouse_wheel <= sat_add(mouse_ack ? {ACC_W{1'b0}} : mouse_wheel,
                             (count >= CNT_W'(4)) ? rx_flat[31:24] : 8'h00);
`endif
    end else if (mouse_ack) begin
      mouse_dx <= '0;
      mouse_dy <= '0;
`ifdef USB_HID_WHEEL_EN
      mouse_wheel <= '0;
`endif
    end
  end

  assign old_code = held[8*int'(slot) +: 8];
  assign new_code = keys[8*int'(slot) +: 8];

  // Diff engine state register
  always_ff @(posedge usbclk or negedge usbrst_n) begin
    if (!usbrst_n) begin
      state     <= S_IDLE;
      slot      <= '0;
      disc_pass <= 1'b0;
    end else begin
      state     <= state_nx;
      slot      <= slot_nx;
      disc_pass <= disc_pass_nx;
    end
  end

  // Diff engine: releases first, then presses; a disconnect runs only the release pass
  always_comb begin
    state_nx     = state;
    slot_nx      = slot;
    disc_pass_nx = disc_pass;
    evt_push     = 1'b0;
    evt_push_dat = 9'h000;
    if (disc) begin
      state_nx     = S_BREAK;
      slot_nx      = '0;
      disc_pass_nx = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (kb_commit) begin
            state_nx     = S_BREAK;
            slot_nx      = '0;
            disc_pass_nx = 1'b0;
          end
        end
        S_BREAK: begin
          if (old_code != 8'h00 && !in_arr(old_code, keys)) begin
            evt_push     = 1'b1;
            evt_push_dat = {1'b0, old_code};
          end
          if (slot == LAST_SLOT) begin
            slot_nx  = '0;
            state_nx = disc_pass ? S_IDLE : S_MAKE;
          end else begin
            slot_nx = slot + 1'b1;
          end
        end
        S_MAKE: begin
          if (new_code != 8'h00 && !in_arr(new_code, held)) begin
            evt_push     = 1'b1;
            evt_push_dat = {1'b1, new_code};
          end
          if (slot == LAST_SLOT) begin
            slot_nx  = '0;
            state_nx = S_IDLE;
          end else begin
            slot_nx = slot + 1'b1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Held-key shadow follows the committed array once a pass completes
  always_ff @(posedge usbclk or negedge usbrst_n) begin
    if (!usbrst_n) held <= '0;
    else if (state == S_MAKE && slot == LAST_SLOT) held <= keys;
    else if (state == S_BREAK && slot == LAST_SLOT && disc_pass) held <= '0;
  end

  hid_evt_fifo #(.W(9), .DEPTH(EVT_DEPTH)) u_evt_fifo (
    .clk      (usbclk),
    .rst_n    (usbrst_n),
    .push     (evt_push),
    .push_dat (evt_push_dat),
    .pop      (evt_ready),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_code  = fifo_empty ? 8'h00 : fifo_dat[7:0];
  assign evt_make  = fifo_empty ? 1'b0  : fifo_dat[8];

  // Sticky overflow: a lost push beats a same-cycle clear
  always_ff @(posedge usbclk or negedge usbrst_n) begin
    if (!usbrst_n) evt_ovf <= 1'b0;
    else if (evt_push && fifo_full && !evt_ready) evt_ovf <= 1'b1;
    else if (evt_ovf_clr) evt_ovf <= 1'b0;
  end
endmodule

// File: tb/tb_usb_hid_report_decoder.sv
// Bench for usb_hid_report_decoder: table of report frames with expected state and events,
// followed by hand-written sequences for saturation, FIFO overflow, disconnect and reset.
module tb_usb_hid_report_decoder;
  localparam int MAXL = 8, NK = 6, AW = 12, ED = 4;

  logic          usbclk = 1'b0;
  logic          usbrst_n = 1'b0;
  logic [1:0]    typ = 2'd0;
  logic          data_rdy = 1'b0, data_strobe = 1'b0;
  logic [7:0]    data = 8'h00;
  logic          report;
  logic [3:0]    report_len;
  logic [7:0]    key_modifiers, mouse_btn, evt_code;
  logic [8*NK-1:0] keys;
  logic [AW-1:0] mouse_dx, mouse_dy;
`ifdef USB_HID_WHEEL_EN
  logic [AW-1:0] mouse_wheel;
`endif
  logic          mouse_ack = 1'b0, evt_ready = 1'b0, evt_ovf_clr = 1'b0;
  logic          evt_valid, evt_make, evt_ovf, busy;

  int checks = 0, errors = 0, report_cnt = 0;

  typedef struct {
    logic [1:0]  typ;
    int          len;
    logic [79:0] b;
    int          pulse;
    logic [3:0]  rlen;
    logic [7:0]  mods;
    logic [47:0] keys;
    logic [7:0]  btn;
    logic [11:0] dx;
    logic [11:0] dy;
    int          nevt;
    logic [8:0]  e0;
    logic [8:0]  e1;
  } vec_t;

  usb_hid_report_decoder #(.MAX_REPORT_LEN(MAXL), .NUM_KEYS(NK), .ACC_W(AW), .EVT_DEPTH(ED)) dut (
    .usbclk(usbclk), .usbrst_n(usbrst_n), .typ(typ), .data_rdy(data_rdy),
    .data_strobe(data_strobe), .data(data), .report(report), .report_len(report_len),
    .key_modifiers(key_modifiers), .keys(keys), .mouse_btn(mouse_btn),
    .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
`ifdef USB_HID_WHEEL_EN
    .mouse_wheel(mouse_wheel),
`endif
    .mouse_ack(mouse_ack), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_make(evt_make), .evt_ovf(evt_ovf),
    .evt_ovf_clr(evt_ovf_clr), .busy(busy)
  );

  always #5 usbclk = ~usbclk;

  // Count report pulses away from the active edge
  always @(negedge usbclk) if (report) report_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge usbclk);
    #1;
  endtask

  task automatic send_frame(input logic [1:0] t, input int len, input logic [79:0] b, input logic ack);
    typ = t;
    data_rdy = 1'b1;
    tick();
    for (int i = 0; i < len; i++) begin
      data = b[8*i +: 8];
      data_strobe = 1'b1;
      tick();
      data_strobe = 1'b0;
      tick();
    end
    data_rdy = 1'b0;
    mouse_ack = ack;
    tick();
    mouse_ack = 1'b0;
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("diff_idle", busy, 0);
  endtask

  task automatic pop_expect(input string name, input logic [8:0] exp);
    int n;
    n = 0;
    while (!evt_valid && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_valid"}, evt_valid, 1);
    chk(name, {evt_make, evt_code}, exp);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  initial begin
    vec_t tbl[11];
    int   rc0, nbusy;

    tbl[0]  = '{2'd1, 8,  80'h00_00_00_00_00_00_00_04_00_00, 1, 4'd8, 8'h00, 48'h0000_0000_0004, 8'h00, 12'h000, 12'h000, 1, 9'h104, 9'h000};
    tbl[1]  = '{2'd1, 8,  80'h0,                             1, 4'd8, 8'h00, 48'h0,              8'h00, 12'h000, 12'h000, 1, 9'h004, 9'h000};
    tbl[2]  = '{2'd1, 8,  80'h00_00_00_00_00_00_05_04_00_02, 1, 4'd8, 8'h02, 48'h0000_0000_0504, 8'h00, 12'h000, 12'h000, 2, 9'h104, 9'h105};
    tbl[3]  = '{2'd1, 8,  80'h00_00_00_00_00_00_06_05_00_00, 1, 4'd8, 8'h00, 48'h0000_0000_0605, 8'h00, 12'h000, 12'h000, 2, 9'h004, 9'h106};
    tbl[4]  = '{2'd1, 8,  80'h00_00_01_01_01_01_01_01_00_00, 0, 4'd8, 8'h00, 48'h0000_0000_0605, 8'h00, 12'h000, 12'h000, 0, 9'h000, 9'h000};
    tbl[5]  = '{2'd1, 5,  80'h00_00_00_00_00_00_00_07_00_00, 0, 4'd8, 8'h00, 48'h0000_0000_0605, 8'h00, 12'h000, 12'h000, 0, 9'h000, 9'h000};
    tbl[6]  = '{2'd2, 3,  80'h00_00_00_00_00_00_00_FB_05_01, 1, 4'd3, 8'h00, 48'h0000_0000_0605, 8'h01, 12'h005, 12'hFFB, 0, 9'h000, 9'h000};
    tbl[7]  = '{2'd2, 4,  80'h00_00_00_00_00_00_7F_10_FE_03, 1, 4'd4, 8'h00, 48'h0000_0000_0605, 8'h03, 12'h003, 12'h00B, 0, 9'h000, 9'h000};
    tbl[8]  = '{2'd2, 2,  80'h00_00_00_00_00_00_00_00_7F_01, 0, 4'd4, 8'h00, 48'h0000_0000_0605, 8'h03, 12'h003, 12'h00B, 0, 9'h000, 9'h000};
    tbl[9]  = '{2'd3, 5,  80'h00_00_00_00_00_EE_DD_CC_BB_AA, 1, 4'd5, 8'h00, 48'h0000_0000_0605, 8'h03, 12'h003, 12'h00B, 0, 9'h000, 9'h000};
    tbl[10] = '{2'd2, 10, 80'h7F_7F_55_55_55_55_55_01_01_00, 1, 4'd8, 8'h00, 48'h0000_0000_0605, 8'h00, 12'h004, 12'h00C, 0, 9'h000, 9'h000};

    // Reset state
    tick(); tick();
    chk("rst_report", report, 0);
    chk("rst_report_len", report_len, 0);
    chk("rst_keys", keys, 0);
    chk("rst_mods", key_modifiers, 0);
    chk("rst_btn", mouse_btn, 0);
    chk("rst_dx", mouse_dx, 0);
    chk("rst_dy", mouse_dy, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt", {evt_make, evt_code}, 0);
    chk("rst_ovf", evt_ovf, 0);
    chk("rst_busy", busy, 0);
    usbrst_n = 1'b1;
    tick();

    // Table of frames
    for (int i = 0; i < 11; i++) begin
      rc0 = report_cnt;
      send_frame(tbl[i].typ, tbl[i].len, tbl[i].b, 1'b0);
      wait_idle();
      chk($sformatf("v%0d_pulses", i), report_cnt - rc0, tbl[i].pulse);
      chk($sformatf("v%0d_report_len", i), report_len, tbl[i].rlen);
      chk($sformatf("v%0d_mods", i), key_modifiers, tbl[i].mods);
      chk($sformatf("v%0d_keys", i), keys, tbl[i].keys);
      chk($sformatf("v%0d_btn", i), mouse_btn, tbl[i].btn);
      chk($sformatf("v%0d_dx", i), mouse_dx, tbl[i].dx);
      chk($sformatf("v%0d_dy", i), mouse_dy, tbl[i].dy);
      if (tbl[i].nevt > 0) pop_expect($sformatf("v%0d_evt0", i), tbl[i].e0);
      if (tbl[i].nevt > 1) pop_expect($sformatf("v%0d_evt1", i), tbl[i].e1);
      chk($sformatf("v%0d_fifo_empty", i), evt_valid, 0);
    end

    // Ack without a commit clears both accumulators
    mouse_ack = 1'b1;
    tick();
    mouse_ack = 1'b0;
    chk("ack_only_dx", mouse_dx, 0);
    chk("ack_only_dy", mouse_dy, 0);

    // Saturation in both directions over 100 reports
    rc0 = report_cnt;
    for (int i = 0; i < 100; i++)
      send_frame(2'd2, 3, 80'h00_00_00_00_00_00_00_80_7F_00, 1'b0);
    chk("sat_pulses", report_cnt - rc0, 100);
    chk("sat_dx_max", mouse_dx, 12'h7FF);
    chk("sat_dy_min", mouse_dy, 12'h800);
    // Ack on the commit cycle: only the new delta remains
    send_frame(2'd2, 3, 80'h00_00_00_00_00_00_00_01_FE_00, 1'b1);
    chk("ack_commit_dx", mouse_dx, 12'hFFE);
    chk("ack_commit_dy", mouse_dy, 12'h001);

    // Release held keys with the consumer draining, then overflow a depth-4 FIFO
    evt_ready = 1'b1;
    send_frame(2'd1, 8, 80'h0, 1'b0);
    wait_idle();
    tick(); tick();
    evt_ready = 1'b0;
    chk("pre_ovf_empty", evt_valid, 0);
    chk("pre_ovf_flag", evt_ovf, 0);
    send_frame(2'd1, 8, 80'h00_00_0F_0E_0D_0C_0B_0A_00_00, 1'b0);
    wait_idle();
    chk("ovf_keys", keys, 48'h0F0E_0D0C_0B0A);
    chk("ovf_set", evt_ovf, 1);
    evt_ovf_clr = 1'b1;
    tick();
    evt_ovf_clr = 1'b0;
    chk("ovf_cleared", evt_ovf, 0);
    pop_expect("ovf_evt0", 9'h10A);
    pop_expect("ovf_evt1", 9'h10B);
    pop_expect("ovf_evt2", 9'h10C);
    pop_expect("ovf_evt3", 9'h10D);
    chk("ovf_fifo_empty", evt_valid, 0);

    // Hold 04,05 (drained), then disconnect
    evt_ready = 1'b1;
    send_frame(2'd1, 8, 80'h00_00_00_00_00_00_05_04_00_00, 1'b0);
    wait_idle();
    tick(); tick();
    evt_ready = 1'b0;
    evt_ovf_clr = 1'b1;
    tick();
    evt_ovf_clr = 1'b0;
    chk("disc_pre_keys", keys, 48'h0000_0000_0504);
    chk("disc_pre_empty", evt_valid, 0);
    typ = 2'd0;
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy) nbusy++;
    end
    chk("disc_busy_cycles", nbusy, NK);
    chk("disc_keys", keys, 0);
    chk("disc_mods", key_modifiers, 0);
    chk("disc_btn", mouse_btn, 0);
    chk("disc_dx_kept", mouse_dx, 12'hFFE);
    pop_expect("disc_evt0", 9'h004);
    pop_expect("disc_evt1", 9'h005);
    chk("disc_fifo_empty", evt_valid, 0);

    // Reset in the middle of a diff pass empties the FIFO at once
    send_frame(2'd1, 8, 80'h00_00_00_00_00_00_05_04_00_00, 1'b0);
    nbusy = 0;
    while (!evt_valid && nbusy < 50) begin
      tick();
      nbusy++;
    end
    chk("mid_diff_evt", evt_valid, 1);
    chk("mid_diff_busy", busy, 1);
    usbrst_n = 1'b0;
    #2;
    chk("arst_evt_valid", evt_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_keys", keys, 0);
    chk("arst_dx", mouse_dx, 0);
    tick();
    usbrst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
